// File: rtl/esn7e_sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
package esn7e_sysid_pkg;

  localparam int unsigned SYSID_DATA_W  = 32;
  localparam int unsigned SYSID_TIMER_W = 16;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_ID        = 32'd0;
  localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_TIMESTAMP = 32'd1470294368;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    FIN   = 2'd3
  } sysid_state_e;

endpackage

// File: rtl/esn7e_stall_timer.sv
// Counts stalled cycles since the last clear; expired is high once the count equals limit.
module esn7e_stall_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  // Counter holds once expired so it can never wrap past the limit.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      count   <= count + W'(1);
      expired <= ((count + W'(1)) == limit);
    end
  end

endmodule

// File: rtl/esn7e_demo_system_sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID, then timestamp) and flags image mismatches.
module esn7e_demo_system_sysid_checker
  import esn7e_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0]  EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [SYSID_DATA_W-1:0]  EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter logic [SYSID_TIMER_W-1:0] TIMEOUT_CYCLES     = 16'd255,
  parameter bit                       AUTO_START         = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  input  logic                    avm_waitrequest,
  output logic                    busy,
  output logic                    done,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    timeout,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  sysid_state_e state;
  logic         pending;
  logic         in_read;
  logic         accept;
  logic         expired;

  assign in_read = (state == RD_ID) || (state == RD_TS);
  assign accept  = in_read && !avm_waitrequest;

  // Clearing outside reads and on every accept restarts the count at each read-state entry.
  esn7e_stall_timer #(.W(SYSID_TIMER_W)) u_stall_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_read || accept),
    .enable  (in_read && avm_waitrequest),
    .limit   (TIMEOUT_CYCLES),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= AUTO_START;
      avm_address <= SYSID_ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // A start landing on the done cycle is dropped, not queued.
          if (pending || (start && !done)) begin
            state       <= RD_ID;
            pending     <= 1'b0;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        RD_ID: begin
          if (!avm_waitrequest) begin
            id_value    <= avm_readdata;
            id_ok       <= (avm_readdata == EXPECTED_ID);
            avm_address <= SYSID_ADDR_TS;
            state       <= RD_TS;
          end else if (expired) begin
            avm_read <= 1'b0;
            timeout  <= 1'b1;
            state    <= FIN;
          end
        end
        RD_TS: begin
          if (!avm_waitrequest) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            avm_read <= 1'b0;
            state    <= FIN;
          end else if (expired) begin
            avm_read <= 1'b0;
            timeout  <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esn7e_demo_system_sysid_checker.sv
// Directed bench: behavioural system-ID slave with programmable per-address stall lengths.
module tb_esn7e_demo_system_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1470294368;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  logic [31:0] id_word, ts_word;
  int          stall_id, stall_ts, stall_ctr;
  logic        read_hist [64];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          n;

  esn7e_demo_system_sysid_checker #(
    .TIMEOUT_CYCLES (16'd8),
    .AUTO_START     (1'b1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  always #5 clock = ~clock;

  // Slave: stalls each read for stall_id/stall_ts cycles; junk data except on accept.
  always_comb begin
    avm_waitrequest = avm_read && (stall_ctr < (avm_address ? stall_ts : stall_id));
    avm_readdata    = (avm_read && !avm_waitrequest) ? (avm_address ? ts_word : id_word)
                                                     : 32'hDEAD_BEEF;
  end

  always @(posedge clock) begin
    if (reset || !avm_read || !avm_waitrequest) stall_ctr <= 0;
    else                                         stall_ctr <= stall_ctr + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Optionally pulses start, then counts edges until done (bounded); checks address stability.
  task automatic run_check(input bit pulse, output int cycles);
    bit   prev_stall;
    logic prev_addr;
    int   slips;
    cycles     = 0;
    prev_stall = 1'b0;
    prev_addr  = 1'b0;
    slips      = 0;
    if (pulse) start = 1'b1;
    do begin
      tick();
      start = 1'b0;
      cycles++;
      if (prev_stall && (avm_address !== prev_addr)) slips++;
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      if (cycles < 64) read_hist[cycles] = avm_read;
    end while (done !== 1'b1 && cycles < 60);
    check("addr_stable_while_stalled", 32'(slips), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    id_word  = 32'd0;
    ts_word  = TS_GOOD;
    stall_id = 0;
    stall_ts = 0;
    tick();
    tick();
    check("rst_read",    32'(avm_read), 32'd0);
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_done",    32'(done),     32'd0);
    check("rst_flags",   32'({id_ok, ts_ok, timeout}), 32'd0);
    check("rst_values",  id_value | ts_value, 32'd0);

    // 1: auto-start after reset, zero-wait slave
    reset = 1'b0;
    run_check(1'b0, n);
    check("t1_done_cycle", 32'(n), 32'd4);
    check("t1_flags",      32'({id_ok, ts_ok, timeout}), 32'b110);
    check("t1_id_value",   id_value, 32'd0);
    check("t1_ts_value",   ts_value, TS_GOOD);
    check("t1_busy",       32'(busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    // 2: wrong ID word
    id_word = 32'h0000_0001;
    run_check(1'b1, n);
    check("t2_done_cycle", 32'(n), 32'd4);
    check("t2_flags",      32'({id_ok, ts_ok, timeout}), 32'b010);
    check("t2_id_value",   id_value, 32'd1);
    tick();
    check("t2_done_once",  32'(done), 32'd0);
    tick();
    check("t2_no_rerun",   32'({done, busy}), 32'd0);

    // 3: three stall cycles on each read
    id_word  = 32'd0;
    stall_id = 3;
    stall_ts = 3;
    run_check(1'b1, n);
    check("t3_done_cycle", 32'(n), 32'd10);
    check("t3_flags",      32'({id_ok, ts_ok, timeout}), 32'b110);
    check("t3_ts_value",   ts_value, TS_GOOD);
    tick();

    // 4: TS read stuck; limit 8 -> timeout after the 9th stalled cycle
    stall_id = 0;
    stall_ts = 1000;
    run_check(1'b1, n);
    check("t4_done_cycle",   32'(n), 32'd12);
    check("t4_read_at_10",   32'(read_hist[10]), 32'd1);
    check("t4_read_at_11",   32'(read_hist[11]), 32'd0);
    check("t4_flags",        32'({id_ok, ts_ok, timeout}), 32'b101);
    tick();

    // 4b: accept on the cycle the limit is reached is a success
    stall_ts = 8;
    run_check(1'b1, n);
    check("t4b_done_cycle", 32'(n), 32'd12);
    check("t4b_flags",      32'({id_ok, ts_ok, timeout}), 32'b110);
    tick();

    // 5: start during RD_TS ignored; start on the done cycle ignored; later start reruns
    stall_ts = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_cleared_on_start", 32'({id_ok, ts_ok, timeout}), 32'b000);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t5_first_done", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_start_on_done_ignored", 32'(busy), 32'd0);
    tick();
    check("t5_rd_ts_start_ignored", 32'({busy, avm_read}), 32'd0);
    id_word = 32'h0000_0001;
    run_check(1'b1, n);
    check("t5_second_cycles", 32'(n), 32'd4);
    check("t5_second_flags",  32'({id_ok, ts_ok, timeout}), 32'b010);
    tick();

    // 6: reset mid RD_ID stall, then auto restart
    id_word  = 32'd0;
    stall_id = 1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t6_reading", 32'(avm_read), 32'd1);
    reset = 1'b1;
    tick();
    check("t6_read_dropped", 32'(avm_read), 32'd0);
    check("t6_flags_clear",  32'({busy, id_ok, ts_ok, timeout}), 32'd0);
    check("t6_values_clear", id_value | ts_value, 32'd0);
    stall_id = 0;
    reset = 1'b0;
    run_check(1'b0, n);
    check("t6_restart_cycles", 32'(n), 32'd4);
    check("t6_restart_flags",  32'({id_ok, ts_ok, timeout}), 32'b110);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
